uart_fmt_mux: RTL and testbench

//  Multi-channel debug-print formatter ahead of the UART TX FIFO. Each of NCH channels

---
 rtl/uart_fmt_mux_pkg.sv | 35 +++
 rtl/uart_fmt_mux_rr_arb.sv | 60 ++++++
 rtl/uart_fmt_mux.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_fmt_mux.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fmt_mux_pkg.sv
// uart_fmt_mux_pkg
//   Shared definitions for the debug-print formatter: FSM state encoding,
//   the ASCII characters the formatter emits, EOL_MODE values and the
//   nibble-to-ASCII conversion used for both register and data digits.
//   No ports (package).
package uart_fmt_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PFX  = 3'd1,
        ST_REG  = 3'd2,
        ST_COL  = 3'd3,
        ST_DAT  = 3'd4,
        ST_EOL1 = 3'd5,
        ST_EOL2 = 3'd6
    } state_e;

    localparam logic [7:0] ASC_R   = 8'h52;  // "R"
    localparam logic [7:0] ASC_COL = 8'h3A;  // ":"
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;

    // EOL_MODE values; mode 0 ("\n" then "\r") is the default fall-through.
    localparam int EOL_CR_LF   = 1;
    localparam int EOL_LF_ONLY = 2;

    // Upper-case hex digit for one nibble.
    function automatic logic [7:0] fn_nib2ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_fmt_mux_rr_arb.sv
// uart_rr_arb
//   Round-robin arbiter over NCH requesters. The search starts at the
//   pointer; the pointer moves to grant+1 (mod NCH) only when en_i is high
//   and some request is present.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : per-requester request
//   en_i       : accept the current grant (advances the pointer)
//   gnt_o      : one-hot grant (combinational)
//   idx_o      : index of the granted requester
//   any_o      : at least one request present
module uart_rr_arb
    import uart_fmt_mux_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req_i,
    input  logic           en_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o,
    output logic           any_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = IW'((int'(ptr_q) + i) % NCH);
            if (!any_o && req_i[cand]) begin
                any_o        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && any_o) begin
            ptr_d = IW'((int'(idx_o) + 1) % NCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_fmt_mux.sv
// uart_fmt_mux
//   Multi-channel debug-print formatter. Each channel strobes a
//   (register, data) pair; pairs are arbitrated round-robin and printed as
//   "R<reg hex>:<data hex><EOL>" on a valid/ready byte stream.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_stb       : per-channel print request pulse
//   i_data      : channel c data at [c*DW +: DW]
//   i_reg       : channel c register number at [c*RW +: RW]
//   o_busy      : channel has a pending or in-progress line
//   o_ovf       : sticky overflow (strobe while busy; request dropped)
//   i_ovf_clr   : clear o_ovf per channel; a same-cycle set wins
//   o_byte      : ASCII character
//   o_byte_vld  : o_byte valid
//   i_byte_rdy  : sink accepts o_byte
module uart_fmt_mux
    import uart_fmt_mux_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DW       = 32,
    parameter int RW       = 4,
    parameter int EOL_MODE = 0,
    parameter int LZS      = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  i_stb,
    input  logic [NCH*DW-1:0] i_data,
    input  logic [NCH*RW-1:0] i_reg,
    output logic [NCH-1:0]  o_busy,
    output logic [NCH-1:0]  o_ovf,
    input  logic [NCH-1:0]  i_ovf_clr,
    output logic [7:0]      o_byte,
    output logic            o_byte_vld,
    input  logic            i_byte_rdy
);

    localparam int NDIG = DW / 4;
    localparam int RDIG = (RW + 3) / 4;
    localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW   = $clog2((NDIG > RDIG) ? NDIG : RDIG) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [NCH-1:0]  busy_q, busy_d;
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic [7:0]      byte_q, byte_d;
    logic            vld_q;
    logic [DW-1:0]   dat_q [NCH];
    logic [RW-1:0]   reg_q [NCH];

    logic            hs;
    logic            line_done;
    logic            arb_en;
    logic            arb_any;
    logic [IW-1:0]   arb_idx;
    logic [DW-1:0]   cur_dat;
    logic [RDIG*4-1:0] cur_reg;

    function automatic logic [3:0] dat_nib(input logic [DW-1:0] d, input logic [CW-1:0] idx);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == CW'(i)) n = d[i*4 +: 4];
        end
        return n;
    endfunction

    function automatic logic [3:0] reg_nib(input logic [RDIG*4-1:0] r, input logic [CW-1:0] idx);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < RDIG; i++) begin
            if (idx == CW'(i)) n = r[i*4 +: 4];
        end
        return n;
    endfunction

    // Index of the most significant non-zero nibble; 0 for an all-zero word
    // so that the last digit is always printed.
    function automatic logic [CW-1:0] dat_msd(input logic [DW-1:0] d);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (d[i*4 +: 4] != 4'h0) r = CW'(i);
        end
        return r;
    endfunction

    uart_rr_arb #(.NCH(NCH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (busy_q),
        .en_i  (arb_en),
        .gnt_o (),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign hs = vld_q & i_byte_rdy;

    // The granted channel's holding registers are frozen while it is busy,
    // so they can be read directly for every digit of the line.
    always_comb begin
        cur_dat          = dat_q[gnt_q];
        cur_reg          = '0;
        cur_reg[RW-1:0]  = reg_q[gnt_q];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        arb_en    = 1'b0;
        line_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Only channels already busy are requesters; a strobe this
                // cycle shows up in busy_q next cycle.
                if (arb_any) begin
                    arb_en  = 1'b1;
                    gnt_d   = arb_idx;
                    state_d = ST_PFX;
                end
            end
            ST_PFX: begin
                if (hs) begin
                    state_d = ST_REG;
                    cnt_d   = CW'(RDIG - 1);
                end
            end
            ST_REG: begin
                if (hs) begin
                    if (cnt_q == '0) state_d = ST_COL;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_COL: begin
                if (hs) begin
                    state_d = ST_DAT;
                    cnt_d   = (LZS != 0) ? dat_msd(cur_dat) : CW'(NDIG - 1);
                end
            end
            ST_DAT: begin
                if (hs) begin
                    if (cnt_q == '0) state_d = ST_EOL1;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_EOL1: begin
                if (hs) begin
                    if (EOL_MODE == EOL_LF_ONLY) begin
                        state_d   = ST_IDLE;
                        line_done = 1'b1;
                    end else begin
                        state_d = ST_EOL2;
                    end
                end
            end
            ST_EOL2: begin
                if (hs) begin
                    state_d   = ST_IDLE;
                    line_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The output byte is registered from the next state, so it holds
    // steady while the sink stalls (next state equals current state).
    always_comb begin
        byte_d = 8'h00;
        unique case (state_d)
            ST_PFX:  byte_d = ASC_R;
            ST_REG:  byte_d = fn_nib2ascii(reg_nib(cur_reg, cnt_d));
            ST_COL:  byte_d = ASC_COL;
            ST_DAT:  byte_d = fn_nib2ascii(dat_nib(cur_dat, cnt_d));
            ST_EOL1: byte_d = (EOL_MODE == EOL_CR_LF) ? ASC_CR : ASC_LF;
            ST_EOL2: byte_d = (EOL_MODE == EOL_CR_LF) ? ASC_LF : ASC_CR;
            default: byte_d = 8'h00;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (line_done) busy_d[gnt_q] = 1'b0;
        busy_d = busy_d | (i_stb & ~busy_q);
        ovf_d  = (ovf_q & ~i_ovf_clr) | (i_stb & busy_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= '0;
            ovf_q   <= '0;
            byte_q  <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            byte_q  <= byte_d;
            vld_q   <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                dat_q[c] <= '0;
                reg_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (i_stb[c] && !busy_q[c]) begin
                    dat_q[c] <= i_data[c*DW +: DW];
                    reg_q[c] <= i_reg[c*RW +: RW];
                end
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_ovf      = ovf_q;
    assign o_byte     = byte_q;
    assign o_byte_vld = vld_q;

endmodule

// File: tb/tb_uart_fmt_mux.sv
// Bench for uart_fmt_mux: two instances (LZS=0 and LZS=1) share stimulus;
// each has its own line-level reference model.
module tb_uart_fmt_mux;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   stb, clr;
    logic [127:0] data;
    logic [15:0]  regs;
    logic         rdy_fixed, rdy_mode, rdy_rnd;
    logic         rdy;
    assign rdy = rdy_mode ? rdy_rnd : rdy_fixed;

    logic [3:0]   obusy [2];
    logic [3:0]   oovf  [2];
    logic [7:0]   ob    [2];
    logic         ovld  [2];

    uart_fmt_mux #(.NCH(4), .DW(32), .RW(4), .EOL_MODE(0), .LZS(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_stb(stb), .i_data(data), .i_reg(regs),
        .o_busy(obusy[0]), .o_ovf(oovf[0]), .i_ovf_clr(clr),
        .o_byte(ob[0]), .o_byte_vld(ovld[0]), .i_byte_rdy(rdy));

    uart_fmt_mux #(.NCH(4), .DW(32), .RW(4), .EOL_MODE(0), .LZS(1)) u_lzs (
        .clk(clk), .rst_n(rst_n), .i_stb(stb), .i_data(data), .i_reg(regs),
        .o_busy(obusy[1]), .o_ovf(oovf[1]), .i_ovf_clr(clr),
        .o_byte(ob[1]), .o_byte_vld(ovld[1]), .i_byte_rdy(rdy));

    int checks = 0;
    int failures = 0;

    function automatic string esc(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] < 8'h20) r = $sformatf("%s~%02h", r, s[i]);
            else              r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chks(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, esc(act), esc(exp));
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one line (a byte array) per instance, built from the
    // textual format, consumed one byte per accepted handshake.
    // ------------------------------------------------------------------
    logic        mact [2];
    int          mpos [2];
    int          mlen [2];
    int          mown [2];
    int          mptr [2];
    logic [3:0]  mbusy [2];
    logic [3:0]  movf  [2];
    logic [31:0] mdat  [2][4];
    logic [3:0]  mreg  [2][4];
    logic [7:0]  mline [2][16];

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'(48 + int'(n));
        return 8'(65 + int'(n) - 10);
    endfunction

    task automatic mpush(input int k, input logic [7:0] b);
        mline[k][mlen[k]] = b;
        mlen[k] = mlen[k] + 1;
    endtask

    task automatic mbuild(input int k, input int g);
        logic       started;
        logic [3:0] nib;
        mlen[k] = 0;
        started = 1'b0;
        mpush(k, 8'h52);
        mpush(k, hexc(mreg[k][g]));
        mpush(k, 8'h3A);
        for (int d = 7; d >= 0; d--) begin
            nib = mdat[k][g][d*4 +: 4];
            if (k == 0 || started || nib != 4'h0 || d == 0) begin
                started = 1'b1;
                mpush(k, hexc(nib));
            end
        end
        mpush(k, 8'h0A);
        mpush(k, 8'h0D);
    endtask

    task automatic mreset(input int k);
        mact[k] = 1'b0; mpos[k] = 0; mlen[k] = 0; mown[k] = 0; mptr[k] = 0;
        mbusy[k] = '0; movf[k] = '0;
        for (int c = 0; c < 4; c++) begin
            mdat[k][c] = '0;
            mreg[k][c] = '0;
        end
    endtask

    task automatic mstep(input int k);
        logic [3:0] prev;
        logic [3:0] nb;
        int         g;
        int         c;
        prev = mbusy[k];
        nb   = mbusy[k];
        g    = -1;
        if (mact[k]) begin
            if (rdy) begin
                mpos[k] = mpos[k] + 1;
                if (mpos[k] == mlen[k]) begin
                    mact[k] = 1'b0;
                    nb[mown[k]] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                c = (mptr[k] + i) % 4;
                if (g < 0 && prev[c]) g = c;
            end
            if (g >= 0) begin
                mbuild(k, g);
                mact[k] = 1'b1;
                mpos[k] = 0;
                mown[k] = g;
                mptr[k] = (g + 1) % 4;
            end
        end
        movf[k] = (movf[k] & ~clr) | (stb & prev);
        for (int i = 0; i < 4; i++) begin
            if (stb[i] && !prev[i]) begin
                nb[i] = 1'b1;
                mdat[k][i] = data[i*32 +: 32];
                mreg[k][i] = regs[i*4 +: 4];
            end
        end
        mbusy[k] = nb;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0);
            mstep(1);
        end
    end

    // Line capture and stall bookkeeping from the DUT side.
    string     cur [2];
    string     lines0 [$];
    string     lines1 [$];
    int        nhs [2];
    logic      stall [2];
    logic [7:0] sbyte [2];

    initial begin
        nhs[0] = 0; nhs[1] = 0;
        cur[0] = ""; cur[1] = "";
        stall[0] = 1'b0; stall[1] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur[0] = ""; cur[1] = "";
            stall[0] = 1'b0; stall[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                stall[k] = ovld[k] && !rdy;
                sbyte[k] = ob[k];
                if (ovld[k] && rdy) begin
                    nhs[k] = nhs[k] + 1;
                    cur[k] = $sformatf("%s%c", cur[k], ob[k]);
                    if (ob[k] == 8'h0D) begin
                        if (k == 0) lines0.push_back(cur[k]);
                        else        lines1.push_back(cur[k]);
                        cur[k] = "";
                    end
                end
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("vld%0d", k), 64'(ovld[k]), 64'(mact[k]));
                chk($sformatf("busy%0d", k), 64'(obusy[k]), 64'(mbusy[k]));
                chk($sformatf("ovf%0d", k), 64'(oovf[k]), 64'(movf[k]));
                if (mact[k]) chk($sformatf("byte%0d", k), 64'(ob[k]), 64'(mline[k][mpos[k]]));
                if (stall[k]) chk($sformatf("stall_hold%0d", k), 64'({ovld[k], ob[k]}), 64'({1'b1, sbyte[k]}));
            end
        end
    end

    always @(negedge clk) begin
        #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    function automatic string get_line(input int k, input int idx);
        if (k == 0) return (idx < lines0.size()) ? lines0[idx] : "";
        return (idx < lines1.size()) ? lines1[idx] : "";
    endfunction

    function automatic int nlines(input int k);
        return (k == 0) ? lines0.size() : lines1.size();
    endfunction

    task automatic wait_lines(input int k, input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (nlines(k) >= n) break;
            @(negedge clk);
        end
        if (nlines(k) < n) begin
            checks++;
            failures++;
            $display("FAIL wait_lines%0d: got %0d lines expected %0d", k, nlines(k), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (obusy[0] == 4'h0 && obusy[1] == 4'h0 && !ovld[0] && !ovld[1]) break;
            @(negedge clk);
        end
        if (obusy[0] != 4'h0 || obusy[1] != 4'h0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got busy %0h/%0h expected 0", obusy[0], obusy[1]);
        end
    endtask

    task automatic strobe(input logic [3:0] m, input logic [31:0] d, input logic [3:0] c_clr);
        @(negedge clk); #1;
        stb = m;
        clr = c_clr;
        for (int c = 0; c < 4; c++) begin
            data[c*32 +: 32] = d + 32'(c);
            regs[c*4 +: 4]   = 4'(c);
        end
        @(negedge clk); #1;
        stb = '0;
        clr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int b0, b1, cnt, h;
        rst_n = 1'b0; stb = '0; clr = '0; data = '0; regs = '0;
        rdy_fixed = 1'b1; rdy_mode = 1'b0; rdy_rnd = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_vld", 64'(ovld[k]), 64'd0);
            chk("rst_byte", 64'(ob[k]), 64'h00);
            chk("rst_busy", 64'(obusy[k]), 64'd0);
            chk("rst_ovf", 64'(oovf[k]), 64'd0);
        end
        #1 rst_n = 1'b1;

        // Case 1: ch2 reg A data 00C0FFEE, sink always ready.
        b0 = lines0.size(); b1 = lines1.size();
        @(negedge clk); #1;
        stb = 4'b0100; data[64 +: 32] = 32'h00C0FFEE; regs[8 +: 4] = 4'hA;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            stb = '0;
            if (obusy[0][2]) cnt++;
            else if (cnt > 0) break;
        end
        // One grant cycle plus one cycle for each of the 13 bytes.
        chk("t1_busy_cycles", 64'(cnt), 64'd14);
        wait_lines(0, b0 + 1, 50);
        wait_lines(1, b1 + 1, 50);
        chks("t1_line", get_line(0, b0), $sformatf("RA:00C0FFEE%c%c", 8'h0A, 8'h0D));
        chks("t1_line_lzs", get_line(1, b1), $sformatf("RA:C0FFEE%c%c", 8'h0A, 8'h0D));
        wait_idle(50);

        // Case 2: zero word and a word with leading zeros.
        b0 = lines0.size(); b1 = lines1.size();
        strobe(4'b0001, 32'h0000_0000, 4'h0);
        wait_lines(0, b0 + 1, 50); wait_lines(1, b1 + 1, 50);
        chks("t2_zero", get_line(0, b0), $sformatf("R0:00000000%c%c", 8'h0A, 8'h0D));
        chks("t2_zero_lzs", get_line(1, b1), $sformatf("R0:0%c%c", 8'h0A, 8'h0D));
        wait_idle(50);
        b0 = lines0.size(); b1 = lines1.size();
        strobe(4'b0001, 32'h0001_F000, 4'h0);
        wait_lines(0, b0 + 1, 50); wait_lines(1, b1 + 1, 50);
        chks("t2_1f", get_line(0, b0), $sformatf("R0:0001F000%c%c", 8'h0A, 8'h0D));
        chks("t2_1f_lzs", get_line(1, b1), $sformatf("R0:1F000%c%c", 8'h0A, 8'h0D));
        wait_idle(50);

        // Case 3: simultaneous requests from a fresh pointer.
        do_reset();
        b0 = lines0.size(); b1 = lines1.size();
        strobe(4'b1011, 32'hC0DE_0000, 4'h0);
        wait_lines(0, b0 + 3, 100); wait_lines(1, b1 + 3, 100);
        chk("t3_order0", 64'(get_line(0, b0)[1]), 64'h30);
        chk("t3_order1", 64'(get_line(0, b0 + 1)[1]), 64'h31);
        chk("t3_order2", 64'(get_line(0, b0 + 2)[1]), 64'h33);
        chks("t3_line3", get_line(0, b0 + 2), $sformatf("R3:C0DE0003%c%c", 8'h0A, 8'h0D));
        wait_idle(50);
        b0 = lines0.size();
        strobe(4'b0011, 32'h0000_0010, 4'h0);
        wait_lines(0, b0 + 2, 100);
        chk("t3_wrap0", 64'(get_line(0, b0)[1]), 64'h30);
        chk("t3_wrap1", 64'(get_line(0, b0 + 1)[1]), 64'h31);
        wait_idle(50);

        // Case 4: case 1 again with a randomly stalling sink.
        b0 = lines0.size();
        rdy_mode = 1'b1;
        @(negedge clk); #1;
        stb = 4'b0100; data[64 +: 32] = 32'h00C0FFEE; regs[8 +: 4] = 4'hA;
        @(negedge clk); #1;
        stb = '0;
        wait_lines(0, b0 + 1, 300);
        chks("t4_line", get_line(0, b0), $sformatf("RA:00C0FFEE%c%c", 8'h0A, 8'h0D));
        wait_idle(300);
        rdy_mode = 1'b0;

        // Case 5: overflow, dropped request, set-wins-over-clear.
        b0 = lines0.size();
        @(negedge clk); #1;
        stb = 4'b0010; data[32 +: 32] = 32'h1234_5678; regs[4 +: 4] = 4'h1;
        @(negedge clk); #1;
        data[32 +: 32] = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        stb = '0;
        chk("t5_ovf_set", 64'(oovf[0][1]), 64'd1);
        wait_idle(60);
        repeat (20) @(negedge clk);
        chk("t5_nlines", 64'(lines0.size()), 64'(b0 + 1));
        chks("t5_line", get_line(0, b0), $sformatf("R1:12345678%c%c", 8'h0A, 8'h0D));
        strobe(4'b0000, 32'h0, 4'b0010);
        chk("t5_ovf_clr", 64'(oovf[0][1]), 64'd0);
        @(negedge clk); #1;
        stb = 4'b0010;
        @(negedge clk); #1;
        clr = 4'b0010;
        @(negedge clk); #1;
        stb = '0; clr = '0;
        chk("t5_set_wins", 64'(oovf[0][1]), 64'd1);
        chk("t5_set_wins_lzs", 64'(oovf[1][1]), 64'd1);
        wait_idle(60);
        strobe(4'b0000, 32'h0, 4'b1111);

        // Case 6: reset in the middle of a line.
        h = nhs[0];
        strobe(4'b0001, 32'h89AB_CDEF, 4'h0);
        for (int i = 0; i < 50; i++) begin
            if (nhs[0] >= h + 5) break;
            @(negedge clk);
        end
        chk("t6_bytes_before", 64'(nhs[0] - h), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_vld_drop", 64'({ovld[0], ovld[1]}), 64'd0);
        chk("t6_busy_drop", 64'({obusy[0], obusy[1]}), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        h = nhs[0] + nhs[1];
        repeat (30) @(negedge clk);
        chk("t6_silent", 64'(nhs[0] + nhs[1]), 64'(h));

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk); #1;
            for (int c = 0; c < 4; c++) begin
                stb[c] = ($urandom_range(0, 7) == 0);
                clr[c] = ($urandom_range(0, 15) == 0);
                data[c*32 +: 32] = $urandom;
                if ($urandom_range(0, 3) == 0) data[c*32 +: 32] = data[c*32 +: 32] >> $urandom_range(0, 31);
                regs[c*4 +: 4] = 4'($urandom_range(0, 15));
            end
            if (i % 300 == 0) rdy_mode = ~rdy_mode;
        end
        @(negedge clk); #1;
        stb = '0; clr = '0; rdy_mode = 1'b0;
        wait_idle(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
